// File: rtl/game_pkg.sv
// Shared lane codes, colour defaults, FSM state encoding and the lane-step helper
// used by the character movement controller.
package game_pkg;

  localparam logic [3:0] POS0 = 4'd0;
  localparam logic [3:0] POS1 = 4'd1;
  localparam logic [3:0] POS2 = 4'd2;
  localparam logic [3:0] POS3 = 4'd3;

  localparam logic [2:0] CHAR_COLOR_DEF = 3'b011;
  localparam logic [2:0] BG_COLOR_DEF   = 3'b000;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_IDLE   = 4'd1,
    S_ERASE  = 4'd2,
    S_WAIT_E = 4'd3,
    S_DRAW   = 4'd4,
    S_WAIT_D = 4'd5
  } move_state_t;

  // One lane to the left or right, clamped to 0..max_pos (never wraps).
  function automatic logic [3:0] step_pos(input logic [3:0] pos, input logic left,
                                          input logic [3:0] max_pos);
    if (left) return (pos == POS0) ? pos : pos - 4'd1;
    else      return (pos >= max_pos) ? pos : pos + 4'd1;
  endfunction

endpackage

// File: rtl/character_move_ctrl_btn_event.sv
// Button front end: 2-flop synchroniser and rising-edge detector producing a one-cycle Event.
// With AUTO_REPEAT_EN defined, a held button (other released) re-fires every REPEAT_CYCLES.
module btn_event
`ifdef AUTO_REPEAT_EN
  #(parameter int REPEAT_CYCLES = 2500000)
`endif
(
  input  logic Clock,
  input  logic Reset,
  input  logic btn,
`ifdef AUTO_REPEAT_EN
  input  logic other,
  output logic level,
`endif
  output logic Event
);

  logic sync1, sync2, prev;
  logic rise;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

`ifdef AUTO_REPEAT_EN
  localparam int CW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(REPEAT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Counter restarts on every edge, clears on release and only runs while the other button is up.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt   <= '0;
      Event <= 1'b0;
    end else begin
      Event <= 1'b0;
      if (rise) begin
        Event <= 1'b1;
        cnt   <= RELOAD;
      end else if (!sync2) begin
        cnt <= '0;
      end else if (other) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        Event <= 1'b1;
        cnt   <= RELOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign level = sync2;
`else
  always_ff @(posedge Clock) begin
    if (!Reset) Event <= 1'b0;
    else        Event <= rise;
  end
`endif

endmodule

// File: rtl/character_move_ctrl.sv
// Lane controller for the character drawer: turns button moves into an erase pass then a draw pass.
// Optional feature macro: AUTO_REPEAT_EN (held-button auto-repeat inside btn_event).
module character_move_ctrl
  import game_pkg::*;
#(
  parameter int         NUM_POS       = 4,
  parameter int         INIT_POS      = 0,
  parameter logic [2:0] CHAR_COLOR    = CHAR_COLOR_DEF,
  parameter logic [2:0] BG_COLOR      = BG_COLOR_DEF,
  parameter int         REPEAT_CYCLES = 2500000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BtnLeft,
  input  logic       BtnRight,
  input  logic       DrawDone,
  output logic       DrawReq,
  output logic [3:0] DrawPos,
  output logic [2:0] DrawColor,
  output logic [3:0] CurPos,
  output logic       Busy
);

  localparam logic [3:0] MAX_POS  = 4'(NUM_POS - 1);
  localparam logic [3:0] INIT_P   = 4'(INIT_POS);

  if (NUM_POS < 2 || NUM_POS > 16 || INIT_POS < 0 || INIT_POS >= NUM_POS || REPEAT_CYCLES < 1)
  begin : g_param_check
    $error("character_move_ctrl: parameter out of range");
  end

  logic left_ev, right_ev, req_valid;

`ifdef AUTO_REPEAT_EN
  logic left_level, right_level;

  btn_event #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_left (
    .Clock(Clock), .Reset(Reset), .btn(BtnLeft),
    .other(right_level), .level(left_level), .Event(left_ev)
  );
  btn_event #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_right (
    .Clock(Clock), .Reset(Reset), .btn(BtnRight),
    .other(left_level), .level(right_level), .Event(right_ev)
  );
`else
  btn_event u_left  (.Clock(Clock), .Reset(Reset), .btn(BtnLeft),  .Event(left_ev));
  btn_event u_right (.Clock(Clock), .Reset(Reset), .btn(BtnRight), .Event(right_ev));
`endif

  // Simultaneous left and right edges cancel out.
  assign req_valid = left_ev ^ right_ev;

  move_state_t state, state_d;
  logic [3:0]  cur_pos, cur_pos_d, target, target_d, next_pos;
  logic [3:0]  draw_pos, draw_pos_d;
  logic [2:0]  draw_color, draw_color_d;
  logic        draw_req, draw_req_d;
  logic [1:0]  guard, guard_d;
  logic        pend_valid, pend_valid_d, pend_left, pend_left_d;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= S_INIT;
      cur_pos    <= INIT_P;
      target     <= INIT_P;
      draw_pos   <= INIT_P;
      draw_color <= CHAR_COLOR;
      draw_req   <= 1'b0;
      guard      <= 2'd0;
      pend_valid <= 1'b0;
      pend_left  <= 1'b0;
    end else begin
      state      <= state_d;
      cur_pos    <= cur_pos_d;
      target     <= target_d;
      draw_pos   <= draw_pos_d;
      draw_color <= draw_color_d;
      draw_req   <= draw_req_d;
      guard      <= guard_d;
      pend_valid <= pend_valid_d;
      pend_left  <= pend_left_d;
    end
  end

  // Handshake: DrawReq is a one-cycle pulse with DrawPos/DrawColor already valid; DrawDone is
  // ignored for that cycle and the next (guard), then sampled as a level until seen high.
  always_comb begin
    state_d      = state;
    cur_pos_d    = cur_pos;
    target_d     = target;
    draw_req_d   = 1'b0;
    draw_pos_d   = draw_pos;
    draw_color_d = draw_color;
    guard_d      = guard;
    pend_valid_d = pend_valid;
    pend_left_d  = pend_left;
    next_pos     = cur_pos;

    if (req_valid) begin
      pend_valid_d = 1'b1;
      pend_left_d  = left_ev;
    end

    case (state)
      S_INIT: begin
        draw_req_d   = 1'b1;
        draw_pos_d   = cur_pos;
        draw_color_d = CHAR_COLOR;
        guard_d      = 2'd2;
        state_d      = S_WAIT_D;
      end
      S_IDLE: begin
        if (req_valid || pend_valid) begin
          pend_valid_d = 1'b0;
          next_pos     = step_pos(cur_pos, req_valid ? left_ev : pend_left, MAX_POS);
          if (next_pos != cur_pos) begin
            target_d = next_pos;
            state_d  = S_ERASE;
          end
        end
      end
      S_ERASE: begin
        draw_req_d   = 1'b1;
        draw_pos_d   = cur_pos;
        draw_color_d = BG_COLOR;
        guard_d      = 2'd2;
        state_d      = S_WAIT_E;
      end
      S_WAIT_E: begin
        if (guard != 2'd0) begin
          guard_d = guard - 2'd1;
        end else if (DrawDone) begin
          cur_pos_d = target;
          state_d   = S_DRAW;
        end
      end
      S_DRAW: begin
        draw_req_d   = 1'b1;
        draw_pos_d   = cur_pos;
        draw_color_d = CHAR_COLOR;
        guard_d      = 2'd2;
        state_d      = S_WAIT_D;
      end
      S_WAIT_D: begin
        if (guard != 2'd0) guard_d = guard - 2'd1;
        else if (DrawDone) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign DrawReq   = draw_req;
  assign DrawPos   = draw_pos;
  assign DrawColor = draw_color;
  assign CurPos    = cur_pos;
  assign Busy      = (state != S_IDLE);

endmodule

// File: tb/tb_character_move_ctrl.sv
// Self-checking bench for character_move_ctrl: drawer model, expected-draw scoreboard and
// a lane-position reference model driven by scenario tasks and randomized moves.
module tb_character_move_ctrl;

  localparam int         NUM_POS = 4;
  localparam logic [2:0] CHAR    = 3'b011;
  localparam logic [2:0] BG      = 3'b000;
`ifdef AUTO_REPEAT_EN
  localparam int RPT = 20;
`else
  localparam int RPT = 2500000;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       BtnLeft = 1'b0;
  logic       BtnRight = 1'b0;
  logic       DrawDone = 1'b1;
  logic       DrawReq;
  logic [3:0] DrawPos;
  logic [2:0] DrawColor;
  logic [3:0] CurPos;
  logic       Busy;

  character_move_ctrl #(
    .NUM_POS(NUM_POS), .INIT_POS(0), .CHAR_COLOR(CHAR), .BG_COLOR(BG), .REPEAT_CYCLES(RPT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .BtnLeft(BtnLeft), .BtnRight(BtnRight),
    .DrawDone(DrawDone), .DrawReq(DrawReq), .DrawPos(DrawPos), .DrawColor(DrawColor),
    .CurPos(CurPos), .Busy(Busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard + drawer model ----------------
  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int done_lat = 10;
  int done_timer = 0;
  int model_pos = 0;
  logic [6:0] exp_q[$];
  logic [6:0] exp_e;

  // Drawer: drops DrawDone on a request and raises it done_lat cycles later, then holds it high.
  always @(negedge Clock) begin
    if (Reset === 1'b1 && DrawReq === 1'b1) begin
      req_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL draw_req_unexpected: got pos=%0d color=%b, required no request", DrawPos, DrawColor);
      end else begin
        exp_e = exp_q.pop_front();
        if ({DrawPos, DrawColor} !== exp_e) begin
          errors++;
          $display("FAIL draw_req_content: got pos=%0d color=%b, required pos=%0d color=%b",
                   DrawPos, DrawColor, exp_e[6:3], exp_e[2:0]);
        end
      end
      done_timer = done_lat;
    end else if (done_timer > 0) begin
      done_timer--;
    end
    DrawDone = (done_timer == 0);
  end

  // Reference model: one move either saturates (nothing drawn) or erases the old lane then draws the new.
  task automatic model_move(input bit left);
    int tgt;
    tgt = left ? model_pos - 1 : model_pos + 1;
    if (tgt < 0) tgt = 0;
    if (tgt > NUM_POS - 1) tgt = NUM_POS - 1;
    if (tgt != model_pos) begin
      exp_q.push_back({4'(model_pos), BG});
      exp_q.push_back({4'(tgt), CHAR});
      model_pos = tgt;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic press(input bit left, input int hold);
    if (left) BtnLeft = 1'b1;
    else      BtnRight = 1'b1;
    tick(hold);
    BtnLeft  = 1'b0;
    BtnRight = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    tick(8);
    for (int k = 0; k < 400; k++) begin
      if (Busy === 1'b0) begin
        got = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL idle_timeout: Busy=%b after 400 cycles, required 0", Busy);
    end
  endtask

  task automatic wait_req(input int target);
    bit got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (req_cnt >= target) begin
        got = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL req_timeout: req_cnt=%0d, required %0d", req_cnt, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int base;
    Reset = 1'b0;
    tick(3);
    checks += 5;
    if (Busy !== 1'b1)      begin errors++; $display("FAIL reset_busy: got %b, required 1", Busy); end
    if (DrawReq !== 1'b0)   begin errors++; $display("FAIL reset_drawreq: got %b, required 0", DrawReq); end
    if (CurPos !== 4'd0)    begin errors++; $display("FAIL reset_curpos: got %0d, required 0", CurPos); end
    if (DrawPos !== 4'd0)   begin errors++; $display("FAIL reset_drawpos: got %0d, required 0", DrawPos); end
    if (DrawColor !== CHAR) begin errors++; $display("FAIL reset_color: got %b, required %b", DrawColor, CHAR); end
    exp_q.delete();
    exp_q.push_back({4'd0, CHAR});
    model_pos = 0;
    base = req_cnt;
    Reset = 1'b1;
    wait_idle();
    checks += 3;
    if (req_cnt - base != 1) begin errors++; $display("FAIL init_req_count: got %0d, required 1", req_cnt - base); end
    if (CurPos !== 4'd0)     begin errors++; $display("FAIL init_curpos: got %0d, required 0", CurPos); end
    if (exp_q.size() != 0)   begin errors++; $display("FAIL init_pending_exp: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_right_move();
    int base, first_k;
    done_lat = 10;
    base = req_cnt;
    first_k = 0;
    model_move(1'b0);
    BtnRight = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clock);
      if (k == 3) BtnRight = 1'b0;
      if (DrawReq === 1'b1 && first_k == 0) first_k = k;
    end
    checks++;
    if (first_k != 5) begin errors++; $display("FAIL move_latency: got %0d cycles, required 5", first_k); end
    wait_idle();
    checks += 3;
    if (CurPos !== 4'd1)     begin errors++; $display("FAIL right_curpos: got %0d, required 1", CurPos); end
    if (req_cnt - base != 2) begin errors++; $display("FAIL right_req_count: got %0d, required 2", req_cnt - base); end
    if (exp_q.size() != 0)   begin errors++; $display("FAIL right_pending_exp: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    int base;
    model_move(1'b1);
    press(1'b1, 3);
    wait_idle();
    base = req_cnt;
    press(1'b1, 3);
    tick(20);
    checks += 2;
    if (req_cnt != base)  begin errors++; $display("FAIL sat_left_req: got %0d reqs, required 0", req_cnt - base); end
    if (CurPos !== 4'd0)  begin errors++; $display("FAIL sat_left_curpos: got %0d, required 0", CurPos); end
    for (int i = 0; i < 3; i++) begin
      model_move(1'b0);
      press(1'b0, 3);
      wait_idle();
    end
    base = req_cnt;
    press(1'b0, 3);
    tick(20);
    checks += 3;
    if (req_cnt != base)   begin errors++; $display("FAIL sat_right_req: got %0d reqs, required 0", req_cnt - base); end
    if (CurPos !== 4'd3)   begin errors++; $display("FAIL sat_right_curpos: got %0d, required 3", CurPos); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL sat_pending_exp: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int base;
    done_lat = 10;
    base = req_cnt;
    model_move(1'b1);  // 3 -> 2
    model_move(1'b1);  // queued left overwrites the right request: 2 -> 1
    press(1'b1, 3);
    wait_req(base + 1);
    tick(1);
    press(1'b0, 3);
    wait_req(base + 2);
    tick(1);
    press(1'b1, 3);
    wait_idle();
    checks += 3;
    if (CurPos !== 4'd1)     begin errors++; $display("FAIL b2b_curpos: got %0d, required 1", CurPos); end
    if (req_cnt - base != 4) begin errors++; $display("FAIL b2b_req_count: got %0d, required 4", req_cnt - base); end
    if (exp_q.size() != 0)   begin errors++; $display("FAIL b2b_pending_exp: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_both_and_reset();
    int base;
    base = req_cnt;
    BtnLeft  = 1'b1;
    BtnRight = 1'b1;
    tick(3);
    BtnLeft  = 1'b0;
    BtnRight = 1'b0;
    tick(20);
    checks += 2;
    if (req_cnt != base) begin errors++; $display("FAIL both_req: got %0d reqs, required 0", req_cnt - base); end
    if (CurPos !== 4'd1) begin errors++; $display("FAIL both_curpos: got %0d, required 1", CurPos); end
    model_move(1'b0);
    press(1'b0, 3);
    wait_idle();
    checks++;
    if (CurPos !== 4'd2) begin errors++; $display("FAIL pre_reset_curpos: got %0d, required 2", CurPos); end
    base = req_cnt;
    exp_q.push_back({4'd2, BG});
    press(1'b0, 3);
    wait_req(base + 1);
    tick(3);
    Reset = 1'b0;
    tick(2);
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b, required 1", Busy); end
    exp_q.delete();
    exp_q.push_back({4'd0, CHAR});
    model_pos = 0;
    Reset = 1'b1;
    wait_idle();
    checks += 3;
    if (CurPos !== 4'd0)     begin errors++; $display("FAIL midreset_curpos: got %0d, required 0", CurPos); end
    if (req_cnt - base != 2) begin errors++; $display("FAIL midreset_req_count: got %0d, required 2", req_cnt - base); end
    if (exp_q.size() != 0)   begin errors++; $display("FAIL midreset_pending_exp: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_random();
    bit left;
    for (int i = 0; i < 16; i++) begin
      done_lat = $urandom_range(1, 12);
      left = 1'($urandom_range(0, 1));
      model_move(left);
      press(left, $urandom_range(2, 6));
      wait_idle();
      checks++;
      if (CurPos !== 4'(model_pos)) begin
        errors++;
        $display("FAIL random_curpos[%0d]: got %0d, required %0d", i, CurPos, model_pos);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_pending_exp: got %0d left, required 0", exp_q.size()); end
    done_lat = 10;
  endtask

`ifdef AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int base;
    Reset = 1'b0;
    tick(2);
    exp_q.delete();
    exp_q.push_back({4'd0, CHAR});
    model_pos = 0;
    Reset = 1'b1;
    wait_idle();
    done_lat = 2;
    base = req_cnt;
    for (int i = 0; i < 4; i++) model_move(1'b0);
    press(1'b0, 70);
    wait_idle();
    checks += 3;
    if (CurPos !== 4'd3)     begin errors++; $display("FAIL repeat_curpos: got %0d, required 3", CurPos); end
    if (req_cnt - base != 6) begin errors++; $display("FAIL repeat_req_count: got %0d, required 6", req_cnt - base); end
    if (exp_q.size() != 0)   begin errors++; $display("FAIL repeat_pending_exp: got %0d left, required 0", exp_q.size()); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_right_move();
    test_saturation();
    test_back_to_back();
    test_both_and_reset();
    test_random();
`ifdef AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
